// File: rtl/mdu_ctrl_pkg.sv
// mdu_ctrl_pkg: shared state encoding, op_i one-hot bit positions and width default
// for the EX-stage multiply/divide sequencer.
`default_nettype none

package mdu_ctrl_pkg;

  localparam int MDU_WIDTH = 32;

  // Bit positions inside op_i; same order as the low 4 bits of hilo_op.
  localparam int OP_MULT  = 3;
  localparam int OP_MULTU = 2;
  localparam int OP_DIV   = 1;
  localparam int OP_DIVU  = 0;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_MUL  = 3'd1,
    ST_DIV  = 3'd2,
    ST_DIVZ = 3'd3,
    ST_DONE = 3'd4
  } mdu_state_t;

endpackage

`default_nettype wire

// File: rtl/mdu_div_step.sv
// mdu_div_step: one restoring-division iteration on a {remainder, dividend/quotient}
// register: shift left, trial subtract, keep the difference and set the quotient bit if no borrow.
`default_nettype none

module mdu_div_step #(
  parameter int WIDTH = 32
) (
  input  logic [2*WIDTH-1:0] rem_quo,
  input  logic [WIDTH-1:0]   divisor,
  output logic [2*WIDTH-1:0] next_rem_quo
);

  logic [2*WIDTH:0] shifted;
  logic [WIDTH:0]   diff;

  assign shifted = {rem_quo, 1'b0};
  // The remainder is always below the divisor, so the shifted top part is below
  // twice the divisor and a successful subtract always fits in WIDTH bits.
  assign diff = shifted[2*WIDTH:WIDTH] - {1'b0, divisor};

  assign next_rem_quo = diff[WIDTH] ? shifted[2*WIDTH-1:0]
                                    : {diff[WIDTH-1:0], shifted[WIDTH-1:1], 1'b1};

endmodule

`default_nettype wire

// File: rtl/mdu_ctrl.sv
// mdu_ctrl: iterative multiply/divide sequencer with pipeline stall request and HI/LO result pulse.
// Optional MDU_FAST_MUL_EN: mult/multu use a single-cycle multiplier (result one cycle after accept).
`default_nettype none

module mdu_ctrl
  import mdu_ctrl_pkg::*;
#(
  parameter int WIDTH = MDU_WIDTH,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             op_valid_i,
  input  logic [3:0]       op_i,
  input  logic [WIDTH-1:0] src1_i,
  input  logic [WIDTH-1:0] src2_i,
  input  logic             annul_i,
  output logic             stallreq_o,
  output logic             busy_o,
  output logic             res_valid_o,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o
);

  mdu_state_t           state;
  logic [CNT_W-1:0]     cnt;
  logic [2*WIDTH-1:0]   acc;
  logic [WIDTH-1:0]     opnd;
  logic                 neg_res;
  logic                 neg_rem;

  logic                 live;
  logic                 op_onehot;
  logic                 is_div_in;
  logic                 is_signed_in;
  logic                 s1_neg;
  logic                 s2_neg;
  logic [WIDTH-1:0]     a_mag;
  logic [WIDTH-1:0]     b_mag;
  logic                 last;

  logic [WIDTH:0]       mul_sum;
  logic [2*WIDTH-1:0]   mul_next;
  logic [2*WIDTH-1:0]   mul_fix;
  logic [2*WIDTH-1:0]   div_next;
  logic [WIDTH-1:0]     quo_fix;
  logic [WIDTH-1:0]     rem_fix;

  assign live         = op_valid_i && !annul_i && !rst;
  assign op_onehot    = (op_i != 4'd0) && ((op_i & (op_i - 4'd1)) == 4'd0);
  assign is_div_in    = op_i[OP_DIV] | op_i[OP_DIVU];
  assign is_signed_in = op_i[OP_MULT] | op_i[OP_DIV];
  assign s1_neg       = is_signed_in & src1_i[WIDTH-1];
  assign s2_neg       = is_signed_in & src2_i[WIDTH-1];
  assign a_mag        = s1_neg ? -src1_i : src1_i;
  assign b_mag        = s2_neg ? -src2_i : src2_i;
  assign last         = (cnt == CNT_W'(WIDTH - 1));

  // Shift-add: multiplier sits in the low half, product grows in from the top.
  assign mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opnd} : {(WIDTH+1){1'b0}});
  assign mul_next = {mul_sum, acc[WIDTH-1:1]};
  assign mul_fix  = neg_res ? -mul_next : mul_next;

  mdu_div_step #(.WIDTH(WIDTH)) u_div_step (
    .rem_quo      (acc),
    .divisor      (opnd),
    .next_rem_quo (div_next)
  );

  assign quo_fix = neg_res ? -div_next[WIDTH-1:0] : div_next[WIDTH-1:0];
  assign rem_fix = neg_rem ? -div_next[2*WIDTH-1:WIDTH] : div_next[2*WIDTH-1:WIDTH];

`ifdef MDU_FAST_MUL_EN
  logic [2*WIDTH-1:0] fast_a;
  logic [2*WIDTH-1:0] fast_b;
  logic [2*WIDTH-1:0] fast_prod;

  assign fast_a    = {{WIDTH{op_i[OP_MULT] & src1_i[WIDTH-1]}}, src1_i};
  assign fast_b    = {{WIDTH{op_i[OP_MULT] & src2_i[WIDTH-1]}}, src2_i};
  assign fast_prod = fast_a * fast_b;
`endif

  always_comb begin
    stallreq_o = 1'b0;
    case (state)
      ST_IDLE: stallreq_o = live && op_onehot;
      ST_DONE: stallreq_o = 1'b0;
      default: stallreq_o = live;
    endcase
  end

  assign busy_o = (state != ST_IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= ST_IDLE;
      cnt         <= '0;
      acc         <= '0;
      opnd        <= '0;
      neg_res     <= 1'b0;
      neg_rem     <= 1'b0;
      res_valid_o <= 1'b0;
      hi_o        <= '0;
      lo_o        <= '0;
    end else begin
      res_valid_o <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (live && op_onehot) begin
            cnt     <= '0;
            neg_res <= s1_neg ^ s2_neg;
            neg_rem <= is_div_in & s1_neg;
            if (is_div_in) begin
              acc   <= {{WIDTH{1'b0}}, a_mag};
              opnd  <= b_mag;
              state <= (src2_i == '0) ? ST_DIVZ : ST_DIV;
            end else begin
`ifdef MDU_FAST_MUL_EN
              state       <= ST_DONE;
              res_valid_o <= 1'b1;
              hi_o        <= fast_prod[2*WIDTH-1:WIDTH];
              lo_o        <= fast_prod[WIDTH-1:0];
`else
              acc   <= {{WIDTH{1'b0}}, b_mag};
              opnd  <= a_mag;
              state <= ST_MUL;
`endif
            end
          end
        end
        ST_MUL: begin
          if (!live) begin
            state <= ST_IDLE;
          end else begin
            acc <= mul_next;
            cnt <= cnt + CNT_W'(1);
            if (last) begin
              state       <= ST_DONE;
              res_valid_o <= 1'b1;
              hi_o        <= mul_fix[2*WIDTH-1:WIDTH];
              lo_o        <= mul_fix[WIDTH-1:0];
            end
          end
        end
        ST_DIV: begin
          if (!live) begin
            state <= ST_IDLE;
          end else begin
            acc <= div_next;
            cnt <= cnt + CNT_W'(1);
            if (last) begin
              state       <= ST_DONE;
              res_valid_o <= 1'b1;
              hi_o        <= rem_fix;
              lo_o        <= quo_fix;
            end
          end
        end
        ST_DIVZ: begin
          if (!live) begin
            state <= ST_IDLE;
          end else begin
            // Re-applying the dividend sign to its magnitude restores src1 exactly.
            state       <= ST_DONE;
            res_valid_o <= 1'b1;
            hi_o        <= neg_rem ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
            lo_o        <= '1;
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_mdu_ctrl.sv
// tb_mdu_ctrl: directed self-checking bench for mdu_ctrl with hand-computed HI/LO results.
`default_nettype none

module tb_mdu_ctrl;

  localparam logic [3:0] OPC_MULT  = 4'b1000;
  localparam logic [3:0] OPC_MULTU = 4'b0100;
  localparam logic [3:0] OPC_DIV   = 4'b0010;
  localparam logic [3:0] OPC_DIVU  = 4'b0001;
`ifdef MDU_FAST_MUL_EN
  localparam int MUL_LAT = 1;
`else
  localparam int MUL_LAT = 33;
`endif
  localparam int DIV_LAT = 33;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        op_valid = 1'b0;
  logic [3:0]  op = 4'd0;
  logic [31:0] src1 = '0;
  logic [31:0] src2 = '0;
  logic        annul = 1'b0;
  logic        stallreq;
  logic        busy;
  logic        res_valid;
  logic [31:0] hi;
  logic [31:0] lo;

  int total = 0;
  int passed = 0;

  mdu_ctrl #(.WIDTH(32), .CNT_W(6)) dut (
    .clk         (clk),
    .rst         (rst),
    .op_valid_i  (op_valid),
    .op_i        (op),
    .src1_i      (src1),
    .src2_i      (src2),
    .annul_i     (annul),
    .stallreq_o  (stallreq),
    .busy_o      (busy),
    .res_valid_o (res_valid),
    .hi_o        (hi),
    .lo_o        (lo)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    assert (got === exp) passed++;
    else $error("FAIL %s: got %h, expected %h", tag, got, exp);
  endtask

  // Issue one operation and hold it in EX until the result pulse; inputs change on negedges.
  task automatic run_op(input string tag, input logic [3:0] opc, input logic [31:0] a,
                        input logic [31:0] b, input int lat,
                        input logic [31:0] ehi, input logic [31:0] elo);
    logic ok;
    ok = 1'b1;
    @(negedge clk);
    op_valid = 1'b1; op = opc; src1 = a; src2 = b;
    #1;
    check({tag, "_stall_accept"}, {63'd0, stallreq}, 64'd1);
    for (int k = 1; k < lat; k++) begin
      @(negedge clk);
      if (!stallreq || res_valid) ok = 1'b0;
    end
    if (lat > 1) check({tag, "_stall_window"}, {63'd0, ok}, 64'd1);
    @(negedge clk);
    check({tag, "_res_valid"}, {63'd0, res_valid}, 64'd1);
    check({tag, "_stall_done"}, {63'd0, stallreq}, 64'd0);
    check({tag, "_hilo"}, {hi, lo}, {ehi, elo});
    op_valid = 1'b0;
    @(negedge clk);
    check({tag, "_pulse_end"}, {62'd0, res_valid, busy}, 64'd0);
    check({tag, "_hilo_hold"}, {hi, lo}, {ehi, elo});
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    repeat (2) @(negedge clk);
    check("reset_outputs", {29'd0, stallreq, busy, res_valid, hi}, 64'd0);
    check("reset_lo", {32'd0, lo}, 64'd0);
    rst = 1'b0;

    run_op("div_100_7",  OPC_DIV,   32'd100,      32'd7,        DIV_LAT, 32'd2,        32'd14);
    run_op("div_m7_2",   OPC_DIV,   32'hFFFF_FFF9, 32'd2,       DIV_LAT, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    run_op("divu_m7_2",  OPC_DIVU,  32'hFFFF_FFF9, 32'd2,       DIV_LAT, 32'd1,        32'h7FFF_FFFC);
    run_op("mult_m1_m1", OPC_MULT,  32'hFFFF_FFFF, 32'hFFFF_FFFF, MUL_LAT, 32'd0,      32'd1);
    run_op("multu_max",  OPC_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, MUL_LAT, 32'hFFFF_FFFE, 32'd1);
    run_op("divu_by0",   OPC_DIVU,  32'h0000_1234, 32'd0,       2,       32'h0000_1234, 32'hFFFF_FFFF);

    // Malformed op encoding is ignored.
    @(negedge clk);
    op_valid = 1'b1; op = 4'b0011; src1 = 32'd5; src2 = 32'd3;
    #1;
    check("bad_op_stall", {63'd0, stallreq}, 64'd0);
    @(negedge clk);
    check("bad_op_idle", {62'd0, busy, res_valid}, 64'd0);
    op_valid = 1'b0;

    // Annul in the middle of a divide.
    @(negedge clk);
    op_valid = 1'b1; op = OPC_DIV; src1 = 32'd100; src2 = 32'd7;
    repeat (10) @(negedge clk);
    check("annul_busy_before", {63'd0, busy}, 64'd1);
    annul = 1'b1;
    #1;
    check("annul_stall_low", {63'd0, stallreq}, 64'd0);
    @(negedge clk);
    annul = 1'b0; op_valid = 1'b0;
    check("annul_idle", {62'd0, busy, res_valid}, 64'd0);
    run_op("mult_after_annul", OPC_MULT, 32'd3, 32'hFFFF_FFFB, MUL_LAT, 32'hFFFF_FFFF, 32'hFFFF_FFF1);

    // op_valid dropping mid-divide behaves like annul.
    @(negedge clk);
    op_valid = 1'b1; op = OPC_DIVU; src1 = 32'd50; src2 = 32'd5;
    repeat (3) @(negedge clk);
    op_valid = 1'b0;
    #1;
    check("drop_stall_low", {63'd0, stallreq}, 64'd0);
    @(negedge clk);
    check("drop_idle", {62'd0, busy, res_valid}, 64'd0);

    // Asynchronous reset between clock edges during a divide.
    @(negedge clk);
    op_valid = 1'b1; op = OPC_DIV; src1 = 32'd100; src2 = 32'd7;
    repeat (5) @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("async_rst_flags", {61'd0, stallreq, busy, res_valid}, 64'd0);
    check("async_rst_hilo", {hi, lo}, 64'd0);
    op_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    run_op("div_min_m1", OPC_DIV, 32'h8000_0000, 32'hFFFF_FFFF, DIV_LAT, 32'd0, 32'h8000_0000);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/mdu_ctrl.md
Name: mdu_ctrl

Overview:
- Multi-cycle multiply/divide sequencer in the EX stage of the 5-stage MIPS pipeline.
- Accepts mult/multu/div/divu operands, runs an iterative 32-step engine and raises stallreq to the stall controller until the HI/LO result is ready.
- Delivers a one-cycle result pulse that EX forwards, with the hi/lo write enables, to ID bypass and to WB.

Parameters:
- WIDTH, 32, operand width; the iteration count equals WIDTH.
- CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
- clk  in  1  core clock
- rst  in  1  asynchronous reset, active-high
- op_valid_i  in  1  EX holds a mult/div instruction this cycle
- op_i  in  4  one-hot {mult, multu, div, divu}; same order as the low 4 bits of hilo_op
- src1_i  in  WIDTH  rs value (multiplicand / dividend)
- src2_i  in  WIDTH  rt value (multiplier / divisor)
- annul_i  in  1  flush of the EX instruction (exception or redirect)
- stallreq_o  out  1  stall request to the stall controller
- busy_o  out  1  engine not IDLE
- res_valid_o  out  1  one-cycle result pulse
- hi_o  out  WIDTH  HI result (product high / remainder)
- lo_o  out  WIDTH  LO result (product low / quotient)

Behaviour:
- Reset (asynchronous): state=IDLE, counter=0, res_valid_o=0, hi_o=0, lo_o=0, busy_o=0, and all operand and partial registers cleared.
- States:
  - IDLE: on op_valid_i && !annul_i, latch |src1|, |src2|, result-sign flags and op. Next state is MUL, DIV, or DIVZ when div/divu has src2_i==0.
  - MUL: shift-add of the unsigned magnitudes into a 2*WIDTH accumulator, one bit per cycle. After WIDTH cycles (counter 0..WIDTH-1), go to DONE.
  - DIV: restoring division on a 2*WIDTH shift register, one quotient bit per cycle. After WIDTH cycles, go to DONE.
  - DIVZ: one cycle, then DONE with hi=src1 as latched and lo=all-ones.
  - DONE: res_valid_o=1 for exactly one cycle; hi_o/lo_o hold the final values; next state IDLE.
- Sign fix is applied on the DIV->DONE and MUL->DONE transitions:
  - mult: negate the 64-bit product if the operand signs differ.
  - div: negate the quotient if the operand signs differ; the remainder takes the sign of the dividend.
  - -2^31 / -1 gives lo=0x8000_0000, hi=0.
- Latency, counting from the accept cycle t:
  - mult/div: DONE at t+WIDTH+1 (t+33 at default).
  - divide-by-zero: DONE at t+2.
- stallreq_o = op_valid_i && !annul_i && (state != DONE). It is combinational, so it is high in the accept cycle. It is low in the DONE cycle so that EX advances with the result.
- Outputs hi_o/lo_o are registered and hold their values after DONE until the next DONE.
- annul_i in any state other than DONE: return to IDLE next cycle with no res_valid_o, and stallreq_o=0 immediately.
- annul_i in DONE: res_valid_o is still driven; EX discards it.
- op_valid_i dropping mid-operation (EX flushed by an upstream stall): treated exactly as annul.
- op_i not one-hot, or all zero, with op_valid_i: ignored; remain IDLE with stallreq_o=0.
- No back-to-back accept: after DONE, at least one IDLE cycle precedes the next accept.

Optional Feature:
- MDU_FAST_MUL_EN defined: mult/multu bypass MUL and compute the product with a single-cycle multiplier into DONE. Latency is t+1 and stallreq is high only in the accept cycle. Division is unchanged.
- Undefined: iterative MUL path as specified above.

Decomposition:
- Shared package / defines header: state encoding (IDLE, MUL, DIV, DIVZ, DONE), the op_i one-hot bit indices, and the WIDTH default.
- Natural sub-module: mdu_div_step, the combinational single-iteration restoring-division step (trial subtract, select, shift). It is instantiated once in the DIV path.

Test Plan:
- div, src1=100, src2=7 -> stallreq high cycles t..t+32, res_valid at t+33, lo=14, hi=2, then IDLE.
- div, src1=-7 (0xFFFF_FFF9), src2=2 -> lo=0xFFFF_FFFD (-3), hi=0xFFFF_FFFF (-1); divu with the same operands -> lo=0x7FFF_FFFC, hi=1.
- mult, src1=0xFFFF_FFFF, src2=0xFFFF_FFFF -> hi=0, lo=1; multu with the same operands -> hi=0xFFFF_FFFE, lo=1. Both at t+33, or t+1 with MDU_FAST_MUL_EN.
- divu, src2=0, src1=0x1234 -> res_valid at t+2, hi=0x1234, lo=0xFFFF_FFFF.
- Start div, assert annul_i at t+10 -> stallreq_o low the same cycle, IDLE at t+11, no res_valid. A new mult accepted at t+12 completes normally.
- Assert rst asynchronously mid-DIV (between clock edges) -> all outputs zero immediately, IDLE. div 0x8000_0000 / 0xFFFF_FFFF after release -> lo=0x8000_0000, hi=0.
